// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: two-port arbiter that serializes Core and Aux accesses
// onto the single-ported data memory (IDLE -> ISSUE -> RESP, one-cycle Ack).
// Optional macro ARBITRO_MEMORIA_DADOS_RR_EN selects round-robin arbitration;
// when undefined, Core has fixed priority over Aux.
module arbitro_memoria_dados #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CoreReq,
  input  logic              CoreWrite,
  input  logic [ADDR_W-1:0] CoreEndereco,
  input  logic [DATA_W-1:0] CoreDadoEscr,
  output logic              CoreAck,
  output logic [DATA_W-1:0] CoreDadoLido,
  input  logic              AuxReq,
  input  logic              AuxWrite,
  input  logic [ADDR_W-1:0] AuxEndereco,
  input  logic [DATA_W-1:0] AuxDadoEscr,
  output logic              AuxAck,
  output logic [DATA_W-1:0] AuxDadoLido,
  output logic [ADDR_W-1:0] MemEndereco,
  output logic [DATA_W-1:0] MemDadoEscr,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemDadoLido,
  output logic              Busy,
  output logic              GrantAux
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] core_rd_q, core_rd_d;
  logic [DATA_W-1:0] aux_rd_q, aux_rd_d;
  logic              any_req;
  logic              arb_edge;
  logic              win_aux;

  assign any_req  = CoreReq | AuxReq;
  assign arb_edge = (state_q == IDLE) || (state_q == RESP);

`ifdef ARBITRO_MEMORIA_DADOS_RR_EN
  logic last_aux_q, last_aux_d;

  // Round-robin winner: on a tie the port that did not own the last transaction wins.
  always_comb begin
    win_aux = AuxReq;
    if (CoreReq && AuxReq) begin
      win_aux = ~last_aux_q;
    end
  end

  // Last-owner tracking updates on every accepted request.
  always_comb begin
    last_aux_d = last_aux_q;
    if (arb_edge && any_req) begin
      last_aux_d = win_aux;
    end
  end

  // Last-owner register; resets to Aux so Core wins the first tie.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      last_aux_q <= 1'b1;
    end else begin
      last_aux_q <= last_aux_d;
    end
  end
`else
  // Fixed priority: Aux wins only when Core is not requesting.
  assign win_aux = AuxReq & ~CoreReq;
`endif

  // Next-state logic: advance the FSM, capture read data, latch a new request on arbitration edges.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    core_rd_d = core_rd_q;
    aux_rd_d  = aux_rd_q;
    case (state_q)
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (!wr_q) begin
          if (owner_q) begin
            aux_rd_d = MemDadoLido;
          end else begin
            core_rd_d = MemDadoLido;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb_edge && any_req) begin
      state_d = ISSUE;
      owner_d = win_aux;
      wr_d    = win_aux ? AuxWrite     : CoreWrite;
      addr_d  = win_aux ? AuxEndereco  : CoreEndereco;
      data_d  = win_aux ? AuxDadoEscr  : CoreDadoEscr;
    end
  end

  // State and datapath registers; async reset clears everything, killing any in-flight access.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      core_rd_q <= '0;
      aux_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      core_rd_q <= core_rd_d;
      aux_rd_q  <= aux_rd_d;
    end
  end

  // Outputs: strobes only in ISSUE, Ack and read-data pass-through only in RESP.
  always_comb begin
    Busy         = (state_q != IDLE);
    GrantAux     = owner_q;
    MemEndereco  = addr_q;
    MemDadoEscr  = data_q;
    MemWrite     = (state_q == ISSUE) &  wr_q;
    MemRead      = (state_q == ISSUE) & ~wr_q;
    CoreAck      = (state_q == RESP) & ~owner_q;
    AuxAck       = (state_q == RESP) &  owner_q;
    CoreDadoLido = core_rd_q;
    AuxDadoLido  = aux_rd_q;
    if ((state_q == RESP) && !wr_q) begin
      if (owner_q) begin
        AuxDadoLido = MemDadoLido;
      end else begin
        CoreDadoLido = MemDadoLido;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// tb_arbitro_memoria_dados: directed and randomized checks of the data-memory
// arbiter against a transaction-level reference model. Honours
// ARBITRO_MEMORIA_DADOS_RR_EN when the design is built with it.
module tb_arbitro_memoria_dados;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CoreReq, CoreWrite, AuxReq, AuxWrite;
  logic [7:0] CoreEndereco, CoreDadoEscr, AuxEndereco, AuxDadoEscr;
  logic       CoreAck, AuxAck;
  logic [7:0] CoreDadoLido, AuxDadoLido;
  logic [7:0] MemEndereco, MemDadoEscr;
  logic       MemWrite, MemRead;
  logic [7:0] MemDadoLido;
  logic       Busy, GrantAux;

  int checks = 0;
  int errors = 0;

  // Environment memory with a backdoor preload port
  logic [7:0] mem [256];
  logic       bd_we;
  logic [7:0] bd_addr, bd_data;

  // Reference model state: expected memory image and per-port last read values
  logic [7:0] ref_mem [256];
  logic [7:0] exp_core_rd, exp_aux_rd;

  arbitro_memoria_dados dut (
    .Clock(Clock), .Reset(Reset),
    .CoreReq(CoreReq), .CoreWrite(CoreWrite), .CoreEndereco(CoreEndereco),
    .CoreDadoEscr(CoreDadoEscr), .CoreAck(CoreAck), .CoreDadoLido(CoreDadoLido),
    .AuxReq(AuxReq), .AuxWrite(AuxWrite), .AuxEndereco(AuxEndereco),
    .AuxDadoEscr(AuxDadoEscr), .AuxAck(AuxAck), .AuxDadoLido(AuxDadoLido),
    .MemEndereco(MemEndereco), .MemDadoEscr(MemDadoEscr), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemDadoLido(MemDadoLido), .Busy(Busy), .GrantAux(GrantAux)
  );

  always #5 Clock = ~Clock;

  // Single-ported synchronous memory: write and registered read at the rising edge
  always @(posedge Clock) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (MemWrite) mem[MemEndereco] <= MemDadoEscr;
    if (MemRead) MemDadoLido <= mem[MemEndereco];
  end

  // Global safety net so the run can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit aux, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    if (aux) begin
      AuxReq = 1'b1; AuxWrite = wr; AuxEndereco = addr; AuxDadoEscr = wd;
    end else begin
      CoreReq = 1'b1; CoreWrite = wr; CoreEndereco = addr; CoreDadoEscr = wd;
    end
  endtask

  // Drop a request and scramble its fields; the latched transaction must not notice
  task automatic dropReq(input bit aux);
    if (aux) begin
      AuxReq = 1'b0; AuxWrite = 1'($urandom); AuxEndereco = 8'($urandom); AuxDadoEscr = 8'($urandom);
    end else begin
      CoreReq = 1'b0; CoreWrite = 1'($urandom); CoreEndereco = 8'($urandom); CoreDadoEscr = 8'($urandom);
    end
  endtask

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    bd_we = 1'b1; bd_addr = addr; bd_data = data;
    @(negedge Clock);
    bd_we = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic resetDut();
    Reset = 1'b0;
    CoreReq = 0; CoreWrite = 0; CoreEndereco = 0; CoreDadoEscr = 0;
    AuxReq = 0; AuxWrite = 0; AuxEndereco = 0; AuxDadoEscr = 0;
    bd_we = 0; bd_addr = 0; bd_data = 0;
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("reset_ctrl", 32'({Busy, CoreAck, AuxAck, MemRead, MemWrite, GrantAux}), 32'd0);
    checkOutput("reset_data", 32'({CoreDadoLido, AuxDadoLido, MemEndereco, MemDadoEscr}), 32'd0);
    Reset = 1'b1;
    exp_core_rd = 8'h00;
    exp_aux_rd  = 8'h00;
  endtask

  // One complete transaction from IDLE: accept, ISSUE, RESP, back to IDLE
  task automatic runTxn(input bit aux, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    applyStimulus(aux, wr, addr, wd);
    @(negedge Clock);
    dropReq(aux);
    checkOutput("issue_strobe", 32'({MemRead, MemWrite}), wr ? 32'd1 : 32'd2);
    checkOutput("issue_addr", 32'(MemEndereco), 32'(addr));
    checkOutput("issue_wdata", 32'(MemDadoEscr), 32'(wd));
    checkOutput("issue_grant_busy", 32'({GrantAux, Busy, CoreAck, AuxAck}), 32'({aux, 1'b1, 2'b00}));
    @(negedge Clock);
    if (wr) ref_mem[addr] = wd;
    else if (aux) exp_aux_rd = ref_mem[addr];
    else exp_core_rd = ref_mem[addr];
    checkOutput("resp_ack", 32'({CoreAck, AuxAck, MemRead, MemWrite}), aux ? 32'b0100 : 32'b1000);
    checkOutput("resp_rdata", 32'({CoreDadoLido, AuxDadoLido}), 32'({exp_core_rd, exp_aux_rd}));
    @(negedge Clock);
    checkOutput("idle_ctrl", 32'({Busy, CoreAck, AuxAck, MemRead, MemWrite}), 32'd0);
    checkOutput("idle_hold", 32'({CoreDadoLido, AuxDadoLido}), 32'({exp_core_rd, exp_aux_rd}));
  endtask

  initial begin
    int core_cnt;
    int aux_cnt;
    bit exp_aux;
    bit rb_aux, rb_wr;
    logic [7:0] ra, rd;

    resetDut();

    // Core read of a preloaded location
    preload(8'h10, 8'hA5);
    runTxn(1'b0, 1'b0, 8'h10, 8'h00);

    // Aux write, then Core reads it back
    runTxn(1'b1, 1'b1, 8'h20, 8'h3C);
    runTxn(1'b0, 1'b0, 8'h20, 8'h00);

    // Early drop of a write request still completes
    runTxn(1'b0, 1'b1, 8'h05, 8'h77);
    checkOutput("early_drop_mem", 32'(mem[8'h05]), 32'h77);
    runTxn(1'b1, 1'b0, 8'h05, 8'h00);

    // Back-to-back Core reads with address advanced on each Ack
    for (int i = 0; i < 4; i++) preload(8'(i), 8'(i + 1));
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      checkOutput("b2b_issue", 32'({Busy, CoreAck, MemRead, MemEndereco}), 32'({3'b101, 8'(i)}));
      @(negedge Clock);
      exp_core_rd = ref_mem[i];
      checkOutput("b2b_ack", 32'({Busy, CoreAck, CoreDadoLido}), 32'({2'b11, exp_core_rd}));
      if (i < 3) CoreEndereco = 8'(i + 1);
      else CoreReq = 1'b0;
    end
    @(negedge Clock);
    checkOutput("b2b_end", 32'({Busy, CoreAck, CoreDadoLido}), 32'({2'b00, exp_core_rd}));

    // Reset asserted during ISSUE of a write
    preload(8'h30, 8'h5E);
    applyStimulus(1'b0, 1'b1, 8'h30, 8'hFF);
    @(posedge Clock);
    #2;
    dropReq(1'b0);
    checkOutput("rst_pre_strobe", 32'(MemWrite), 32'd1);
    Reset = 1'b0;
    #1;
    checkOutput("rst_async_drop", 32'({MemWrite, MemRead, Busy, CoreAck, AuxAck}), 32'd0);
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("rst_no_ack", 32'({CoreAck, AuxAck, Busy}), 32'd0);
    checkOutput("rst_mem_kept", 32'(mem[8'h30]), 32'(ref_mem[8'h30]));
    Reset = 1'b1;
    exp_core_rd = 8'h00;
    exp_aux_rd  = 8'h00;
    runTxn(1'b0, 1'b0, 8'h30, 8'h00);

    // Contention: both ports hold read requests for eight transactions
    resetDut();
    applyStimulus(1'b0, 1'b0, 8'h10, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00);
    core_cnt = 0;
    aux_cnt  = 0;
    for (int k = 0; k < 8; k++) begin
`ifdef ARBITRO_MEMORIA_DADOS_RR_EN
      exp_aux = (k % 2) == 1;
`else
      exp_aux = 1'b0;
`endif
      @(negedge Clock);
      checkOutput("cont_issue", 32'({CoreAck, AuxAck, GrantAux}), 32'({2'b00, exp_aux}));
      @(negedge Clock);
      if (exp_aux) exp_aux_rd = ref_mem[8'h20];
      else exp_core_rd = ref_mem[8'h10];
      checkOutput("cont_ack", 32'({CoreAck, AuxAck}), exp_aux ? 32'b01 : 32'b10);
      checkOutput("cont_rdata", 32'({CoreDadoLido, AuxDadoLido}), 32'({exp_core_rd, exp_aux_rd}));
      core_cnt += int'(CoreAck);
      aux_cnt  += int'(AuxAck);
      if (k == 7) begin
        CoreReq = 1'b0;
        AuxReq  = 1'b0;
      end
    end
    @(negedge Clock);
    checkOutput("cont_idle", 32'(Busy), 32'd0);
`ifdef ARBITRO_MEMORIA_DADOS_RR_EN
    checkOutput("cont_counts", 32'({8'(core_cnt), 8'(aux_cnt)}), 32'({8'd4, 8'd4}));
`else
    checkOutput("cont_counts", 32'({8'(core_cnt), 8'(aux_cnt)}), 32'({8'd8, 8'd0}));
`endif

    // Randomized single-port transactions over a preloaded window
    for (int i = 0; i < 8; i++) preload(8'(8'h40 + i), 8'($urandom));
    for (int n = 0; n < 24; n++) begin
      rb_aux = 1'($urandom);
      rb_wr  = 1'($urandom);
      ra     = 8'(8'h40 + $urandom_range(0, 7));
      rd     = 8'($urandom);
      runTxn(rb_aux, rb_wr, ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria_dados.md
# arbitro_memoria_dados

Two-port arbiter that shares the single-ported 8-bit data memory between the nRisc core (Core port) and an auxiliary master (Aux port, e.g. loader or debug DMA). It sits between the core's data-memory bus and the data memory and owns that memory's `MenRead`/`MenWrite` strobes. It serializes accesses through a small FSM and returns a one-cycle acknowledge with read data to the winning requester.

## Interface
Parameters:
- `ADDR_W`, 8, address width.
- `DATA_W`, 8, data width.

Ports:
- `Clock`  in  1  system clock; all state changes on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `CoreReq`  in  1  Core access request.
- `CoreWrite`  in  1  1 = write, 0 = read; qualified by `CoreReq`.
- `CoreEndereco`  in  ADDR_W  Core address.
- `CoreDadoEscr`  in  DATA_W  Core write data.
- `CoreAck`  out  1  one-cycle completion pulse.
- `CoreDadoLido`  out  DATA_W  Core read data.
- `AuxReq`, `AuxWrite`, `AuxEndereco`, `AuxDadoEscr`, `AuxAck`, `AuxDadoLido`: identical to the Core set, for the Aux port.
- `MemEndereco`  out  ADDR_W  memory address.
- `MemDadoEscr`  out  DATA_W  memory write data.
- `MemWrite`  out  1  memory write strobe.
- `MemRead`  out  1  memory read strobe.
- `MemDadoLido`  in  DATA_W  memory read data; valid one edge after `MemRead`.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `GrantAux`  out  1  current owner: 1 = Aux, 0 = Core; valid in ISSUE and RESP.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No `*Req` → stay in IDLE.
  - Any `*Req` → pick a winner, latch owner, write flag, address and data into internal registers, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `MemEndereco` and `MemDadoEscr` come from the latched registers.
  - `MemWrite` = latched write flag; `MemRead` = its inverse.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Owner's `*Ack` = 1.
  - For a read, the owner's `*DadoLido` passes `MemDadoLido` through and loads its holding register at the exit edge.
  - At the exit edge, arbitrate again: any `*Req` → ISSUE with a new latch; none → IDLE.
- Data hold:
  - `*DadoLido` keeps the last value read by that port until that port completes another read.
  - A write never changes either `*DadoLido`.
- Request handling:
  - A request is sampled only on arbitration edges (IDLE, or the RESP exit edge).
  - After latching, changes to Req, address or data are ignored until Ack.
  - Dropping Req early does not cancel the transaction; Ack still fires.
  - Req still high at the edge that ends Ack counts as a new request.
- Memory strobes are 0 in IDLE and RESP. `MemEndereco` and `MemDadoEscr` hold their last values.
- Arbitration without the config macro: fixed priority, Core over Aux.
- Reset (async, `Reset`=0):
  - state = IDLE; all outputs 0; both holding registers = 0.
  - Round-robin last-owner = Aux.
  - Reset asserted in ISSUE drops `MemWrite`/`MemRead` immediately, so no memory write occurs at the next edge. No Ack is issued and the transaction is lost.

## Timing
- E0 = edge that accepts a request.
  - Strobe asserted in cycle E0–E1.
  - Memory acts at E1.
  - Ack and read data valid in cycle E1–E2.
  - Next arbitration at E2.
- Latency: Req sampled to Ack asserted = 1 cycle after the strobe cycle.
- Throughput: one transaction per 2 cycles; back-to-back transactions add no IDLE cycle.
- Ack is exactly 1 cycle wide and never high on both ports at once.

## Configuration
- Macro: `ARBITRO_MEMORIA_DADOS_RR_EN`.
- Defined: round-robin arbitration.
  - On simultaneous requests, the port that did not own the previous transaction wins.
  - A single requester always wins.
  - Last-owner register updates at each accept.
- Undefined: fixed priority, Core always wins; last-owner register is not built.

## Test plan
- Core read: mem[0x10]=0xA5, CoreReq=1, CoreWrite=0, CoreEndereco=0x10 → `MemRead`=1 for exactly one cycle with `MemEndereco`=0x10; `CoreAck` one cycle later; `CoreDadoLido`=0xA5 and held after Ack.
- Aux write, then Core read: Aux writes 0x3C to 0x20, then Core reads 0x20 → `AuxAck` one pulse with `AuxDadoLido` still 0x00; `CoreDadoLido`=0x3C.
- Contention: both Req held high for 8 transactions →
  - without macro: 8 `CoreAck`, 0 `AuxAck`;
  - with macro: Acks alternate Core, Aux, Core, Aux…, Core first after reset.
- Back-to-back: Core holds Req while incrementing address 0x00–0x03 on each Ack, mem[i]=i+1 → four `CoreAck` pulses exactly 2 cycles apart, returning data 0x01–0x04; `Busy` never drops.
- Early drop: CoreReq high for only the accept edge, write 0x77 to 0x05 → `CoreAck` still fires; mem[0x05]=0x77.
- Reset mid-write: `Reset`=0 during ISSUE of a write of 0xFF to 0x30 → `MemWrite` drops to 0 asynchronously; mem[0x30] unchanged; no Ack; `Busy`=0; after release, the next request is served normally.
